// File: rtl/beta_pkg.sv
// Shared types and constants for the beta writeback stage.
package beta_pkg;

  localparam int unsigned NumRegs = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/beta_writeback_if.sv
// Result, register-file, forwarding and stall signals of the writeback stage.
interface beta_writeback_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5
);

  logic                 alu_valid_i;
  logic [AddrWidth-1:0] alu_rd_i;
  logic [DataWidth-1:0] alu_data_i;

  logic                 lsu_valid_i;
  logic                 lsu_ready_o;
  logic [AddrWidth-1:0] lsu_rd_i;
  logic [DataWidth-1:0] lsu_data_i;

  logic                 rf_wr_en_o;
  logic [AddrWidth-1:0] rf_rd_addr_o;
  logic [DataWidth-1:0] rf_rd_wdata_o;

  logic [AddrWidth-1:0] rs1_addr_i;
  logic [AddrWidth-1:0] rs2_addr_i;

  logic                 fwd_rs1_en_o;
  logic                 fwd_rs2_en_o;
  logic [DataWidth-1:0] fwd_rs1_data_o;
  logic [DataWidth-1:0] fwd_rs2_data_o;

  logic                 stall_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  rs1_addr_i, rs2_addr_i,
    output lsu_ready_o,
    output rf_wr_en_o, rf_rd_addr_o, rf_rd_wdata_o,
    output fwd_rs1_en_o, fwd_rs2_en_o, fwd_rs1_data_o, fwd_rs2_data_o,
    output stall_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output rs1_addr_i, rs2_addr_i,
    input  lsu_ready_o,
    input  rf_wr_en_o, rf_rd_addr_o, rf_rd_wdata_o,
    input  fwd_rs1_en_o, fwd_rs2_en_o, fwd_rs1_data_o, fwd_rs2_data_o,
    input  stall_o
  );

endinterface

// File: rtl/beta_wb_holdbuf.sv
// Single-entry hold buffer: parks the result that lost write-port arbitration.
module beta_wb_holdbuf
  import beta_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_alu_valid,
  input  logic [AddrWidth-1:0] i_alu_rd,
  input  logic [DataWidth-1:0] i_alu_data,
  input  logic                 i_lsu_valid,
  input  logic [AddrWidth-1:0] i_lsu_rd,
  input  logic [DataWidth-1:0] i_lsu_data,
  output logic                 o_full,
  output logic [AddrWidth-1:0] o_hold_rd,
  output logic [DataWidth-1:0] o_hold_data
);

  wb_state_e            r_state;
  wb_state_e            w_state_next;
  logic                 w_load;
  logic [AddrWidth-1:0] w_load_rd;
  logic [DataWidth-1:0] w_load_data;
  logic [AddrWidth-1:0] r_hold_rd;
  logic [DataWidth-1:0] r_hold_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // While FULL the held entry drains every cycle; a concurrent ALU result takes its place.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_rd    = i_lsu_rd;
    w_load_data  = i_lsu_data;
    case (r_state)
      EMPTY: begin
        if (i_alu_valid && i_lsu_valid) begin
          w_state_next = FULL;
          w_load       = 1'b1;
        end
      end
      FULL: begin
        if (i_alu_valid) begin
          w_load      = 1'b1;
          w_load_rd   = i_alu_rd;
          w_load_data = i_alu_data;
        end else begin
          w_state_next = EMPTY;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_rd   <= '0;
      r_hold_data <= '0;
    end else if (w_load) begin
      r_hold_rd   <= w_load_rd;
      r_hold_data <= w_load_data;
    end
  end

  assign o_full      = (r_state == FULL);
  assign o_hold_rd   = r_hold_rd;
  assign o_hold_data = r_hold_data;

endmodule

// File: rtl/beta_writeback.sv
// Writeback stage: arbitrates ALU/LSU results onto the register-file write port with bypass.
module beta_writeback
  import beta_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5
) (
  input logic              clk_i,
  input logic              rst_i,
  beta_writeback_if.slave  bus
);

  logic                 w_full;
  logic [AddrWidth-1:0] w_hold_rd;
  logic [DataWidth-1:0] w_hold_data;

  logic                 w_sel_valid;
  logic [AddrWidth-1:0] w_sel_rd;
  logic [DataWidth-1:0] w_sel_data;

  logic                 r_wr_en;
  logic [AddrWidth-1:0] r_rd_addr;
  logic [DataWidth-1:0] r_rd_wdata;

  logic                 w_fwd1_en;
  logic                 w_fwd2_en;

  beta_wb_holdbuf #(
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth)
  ) u_holdbuf (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_alu_valid (bus.alu_valid_i),
    .i_alu_rd    (bus.alu_rd_i),
    .i_alu_data  (bus.alu_data_i),
    .i_lsu_valid (bus.lsu_valid_i),
    .i_lsu_rd    (bus.lsu_rd_i),
    .i_lsu_data  (bus.lsu_data_i),
    .o_full      (w_full),
    .o_hold_rd   (w_hold_rd),
    .o_hold_data (w_hold_data)
  );

  // Held entry is always oldest, so it wins; the LSU is only eligible while EMPTY.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rd    = bus.alu_rd_i;
    w_sel_data  = bus.alu_data_i;
    if (w_full) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = w_hold_rd;
      w_sel_data  = w_hold_data;
    end else if (bus.alu_valid_i) begin
      w_sel_valid = 1'b1;
    end else if (bus.lsu_valid_i) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = bus.lsu_rd_i;
      w_sel_data  = bus.lsu_data_i;
    end
  end

  // Writes to r0 are consumed but never reach the register file.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_wdata <= '0;
    end else begin
      r_wr_en <= w_sel_valid && (w_sel_rd != '0);
      if (w_sel_valid) begin
        r_rd_addr  <= w_sel_rd;
        r_rd_wdata <= w_sel_data;
      end
    end
  end

  assign w_fwd1_en = r_wr_en && (r_rd_addr == bus.rs1_addr_i) && (bus.rs1_addr_i != '0);
  assign w_fwd2_en = r_wr_en && (r_rd_addr == bus.rs2_addr_i) && (bus.rs2_addr_i != '0);

  assign bus.lsu_ready_o    = !w_full;
  assign bus.rf_wr_en_o     = r_wr_en;
  assign bus.rf_rd_addr_o   = r_rd_addr;
  assign bus.rf_rd_wdata_o  = r_rd_wdata;
  assign bus.fwd_rs1_en_o   = w_fwd1_en;
  assign bus.fwd_rs2_en_o   = w_fwd2_en;
  assign bus.fwd_rs1_data_o = w_fwd1_en ? r_rd_wdata : '0;
  assign bus.fwd_rs2_data_o = w_fwd2_en ? r_rd_wdata : '0;
  assign bus.stall_o        = w_full && (w_hold_rd != '0) &&
                              ((w_hold_rd == bus.rs1_addr_i) || (w_hold_rd == bus.rs2_addr_i));

endmodule

// File: tb/tb_beta_writeback.sv
// Directed self-checking bench for beta_writeback.
module tb_beta_writeback;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  beta_writeback_if #(.DataWidth(32), .AddrWidth(5)) bus ();

  beta_writeback #(.DataWidth(32), .AddrWidth(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] addr,
                        input logic [31:0] data);
    chk({tag, "_en"}, 32'(bus.rf_wr_en_o), 32'(en));
    if (en) begin
      chk({tag, "_addr"}, 32'(bus.rf_rd_addr_o), 32'(addr));
      chk({tag, "_data"}, bus.rf_rd_wdata_o, data);
    end
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid_i = v;
    bus.alu_rd_i    = rd;
    bus.alu_data_i  = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_valid_i = v;
    bus.lsu_rd_i    = rd;
    bus.lsu_data_i  = d;
  endtask

  initial begin
    rst = 1'b1;
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    bus.rs1_addr_i = 5'd0;
    bus.rs2_addr_i = 5'd0;

    // Reset state
    step();
    step();
    chk("rst_wr_en", 32'(bus.rf_wr_en_o), 32'd0);
    chk("rst_addr", 32'(bus.rf_rd_addr_o), 32'd0);
    chk("rst_wdata", bus.rf_rd_wdata_o, 32'd0);
    chk("rst_ready", 32'(bus.lsu_ready_o), 32'd1);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_fwd1", 32'(bus.fwd_rs1_en_o), 32'd0);
    chk("rst_fwd2", 32'(bus.fwd_rs2_en_o), 32'd0);
    rst = 1'b0;

    // Plain ALU write with forward on rs1
    bus.rs1_addr_i = 5'd5;
    set_alu(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    chk_wr("alu5", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("alu5_fwd1_en", 32'(bus.fwd_rs1_en_o), 32'd1);
    chk("alu5_fwd1_data", bus.fwd_rs1_data_o, 32'hDEADBEEF);
    chk("alu5_fwd2_en", 32'(bus.fwd_rs2_en_o), 32'd0);
    set_alu(1'b0, 5'd0, 32'h0);
    step();
    chk_wr("idle", 1'b0, 5'd0, 32'h0);

    // ALU and LSU together: ALU first, load held one cycle
    bus.rs1_addr_i = 5'd0;
    bus.rs2_addr_i = 5'd4;
    set_alu(1'b1, 5'd3, 32'h11);
    set_lsu(1'b1, 5'd4, 32'h22);
    step();
    chk_wr("dual_c1", 1'b1, 5'd3, 32'h11);
    chk("dual_c1_ready", 32'(bus.lsu_ready_o), 32'd0);
    chk("dual_c1_stall", 32'(bus.stall_o), 32'd1);
    chk("dual_c1_fwd2", 32'(bus.fwd_rs2_en_o), 32'd0);
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    step();
    chk_wr("dual_c2", 1'b1, 5'd4, 32'h22);
    chk("dual_c2_fwd2_en", 32'(bus.fwd_rs2_en_o), 32'd1);
    chk("dual_c2_fwd2_data", bus.fwd_rs2_data_o, 32'h22);
    chk("dual_c2_stall", 32'(bus.stall_o), 32'd0);
    step();
    chk("dual_c3_ready", 32'(bus.lsu_ready_o), 32'd1);
    chk_wr("dual_c3", 1'b0, 5'd0, 32'h0);

    // Held load rd=7 stalls rs1=7 until it is written and forwarded
    bus.rs1_addr_i = 5'd7;
    bus.rs2_addr_i = 5'd0;
    set_alu(1'b1, 5'd9, 32'h99);
    set_lsu(1'b1, 5'd7, 32'hCAFE0007);
    step();
    chk("hold7_stall", 32'(bus.stall_o), 32'd1);
    chk("hold7_fwd1_pre", 32'(bus.fwd_rs1_en_o), 32'd0);
    chk_wr("hold7_alu", 1'b1, 5'd9, 32'h99);
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    step();
    chk("hold7_stall_done", 32'(bus.stall_o), 32'd0);
    chk("hold7_fwd1_en", 32'(bus.fwd_rs1_en_o), 32'd1);
    chk("hold7_fwd1_data", bus.fwd_rs1_data_o, 32'hCAFE0007);
    chk_wr("hold7_wr", 1'b1, 5'd7, 32'hCAFE0007);

    // rd=0 is consumed silently, no forwarding on r0
    bus.rs1_addr_i = 5'd0;
    set_alu(1'b1, 5'd0, 32'hFFFF);
    step();
    set_alu(1'b0, 5'd0, 32'h0);
    chk("r0_wr_en", 32'(bus.rf_wr_en_o), 32'd0);
    chk("r0_fwd1", 32'(bus.fwd_rs1_en_o), 32'd0);
    chk("r0_fwd2", 32'(bus.fwd_rs2_en_o), 32'd0);
    chk("r0_fwd1_data", bus.fwd_rs1_data_o, 32'd0);
    chk("r0_ready", 32'(bus.lsu_ready_o), 32'd1);

    // FULL with ALU for 3 cycles; waiting LSU keeps its data stable until ready
    set_alu(1'b1, 5'd1, 32'hA1);
    set_lsu(1'b1, 5'd2, 32'hB2);
    step();
    chk_wr("seq_e1", 1'b1, 5'd1, 32'hA1);
    chk("seq_e1_ready", 32'(bus.lsu_ready_o), 32'd0);
    set_alu(1'b1, 5'd2, 32'hC2);
    set_lsu(1'b1, 5'd6, 32'h66);
    step();
    chk_wr("seq_e2", 1'b1, 5'd2, 32'hB2);
    chk("seq_e2_ready", 32'(bus.lsu_ready_o), 32'd0);
    set_alu(1'b1, 5'd3, 32'hC3);
    step();
    chk_wr("seq_e3", 1'b1, 5'd2, 32'hC2);
    chk("seq_e3_ready", 32'(bus.lsu_ready_o), 32'd0);
    set_alu(1'b1, 5'd4, 32'hC4);
    step();
    chk_wr("seq_e4", 1'b1, 5'd3, 32'hC3);
    chk("seq_e4_ready", 32'(bus.lsu_ready_o), 32'd0);
    set_alu(1'b0, 5'd0, 32'h0);
    step();
    chk_wr("seq_e5", 1'b1, 5'd4, 32'hC4);
    chk("seq_e5_ready", 32'(bus.lsu_ready_o), 32'd1);
    step();
    chk_wr("seq_e6_lsu", 1'b1, 5'd6, 32'h66);
    set_lsu(1'b0, 5'd0, 32'h0);
    step();
    chk_wr("seq_e7", 1'b0, 5'd0, 32'h0);

    // Reset while FULL discards the held entry
    bus.rs1_addr_i = 5'd11;
    set_alu(1'b1, 5'd10, 32'hAA);
    set_lsu(1'b1, 5'd11, 32'hBB);
    step();
    chk_wr("rstf_e1", 1'b1, 5'd10, 32'hAA);
    chk("rstf_e1_stall", 32'(bus.stall_o), 32'd1);
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    step();
    chk("rstf_wr_en", 32'(bus.rf_wr_en_o), 32'd0);
    chk("rstf_ready", 32'(bus.lsu_ready_o), 32'd1);
    chk("rstf_stall", 32'(bus.stall_o), 32'd0);
    rst = 1'b0;
    step();
    chk("rstf_after_wr_en", 32'(bus.rf_wr_en_o), 32'd0);
    chk("rstf_after_ready", 32'(bus.lsu_ready_o), 32'd1);
    chk("rstf_after_fwd1", 32'(bus.fwd_rs1_en_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beta_writeback.md
BETA_WRITEBACK -- requirements
Module: beta_writeback

Interface
REQ-001 The module SHALL have parameter DataWidth, default 32, meaning the width of the result and register data paths.
REQ-002 The module SHALL have parameter AddrWidth, default 5, meaning the register index width.
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have ports alu_valid_i (input, 1), alu_rd_i (input, AddrWidth) and alu_data_i (input, DataWidth): the ALU result. It has no ready signal and is always accepted.
REQ-006 The module SHALL have ports lsu_valid_i (input, 1), lsu_ready_o (output, 1), lsu_rd_i (input, AddrWidth) and lsu_data_i (input, DataWidth): the load result, using a valid/ready handshake.
REQ-007 The module SHALL have ports rf_wr_en_o (output, 1), rf_rd_addr_o (output, AddrWidth) and rf_rd_wdata_o (output, DataWidth): these drive the register-file write port.
REQ-008 The module SHALL have ports rs1_addr_i and rs2_addr_i (input, AddrWidth): the decode-stage read addresses.
REQ-009 The module SHALL have ports fwd_rs1_en_o, fwd_rs2_en_o (output, 1), fwd_rs1_data_o and fwd_rs2_data_o (output, DataWidth): the bypass outputs.
REQ-010 The module SHALL have port stall_o, output, 1 bit: asserted while a held load targets rs1 or rs2.

Function
REQ-011 The write-port outputs SHALL be registered, giving 1-cycle latency from an accepted result to rf_wr_en_o.
REQ-012 The source-select priority SHALL be, highest first: hold buffer, then ALU, then LSU.
REQ-013 The hold buffer SHALL be a single entry with states EMPTY and FULL.
REQ-014 In EMPTY, if ALU and LSU are both valid while lsu_ready_o=1, the ALU SHALL be written and the LSU entry captured into the hold buffer (transition to FULL).
REQ-015 In FULL, the held entry SHALL be written; the ALU, if valid in the same cycle, SHALL be captured into the hold buffer so the state remains FULL.
REQ-016 In FULL with alu_valid_i=0, the held entry SHALL be written and the state SHALL return to EMPTY.
REQ-017 lsu_ready_o SHALL equal 1 exactly when the state is EMPTY; it is registered-state derived, with no combinational path from the valid inputs.
REQ-018 An LSU transfer SHALL occur only when lsu_valid_i=1 and lsu_ready_o=1 in the same cycle; the LSU holds its data stable while ready=0.
REQ-019 A result with rd=0 SHALL be consumed normally but SHALL produce rf_wr_en_o=0.
REQ-020 fwd_rsN_en_o SHALL be 1 when rf_wr_en_o=1, rf_rd_addr_o equals rsN_addr_i, and rsN_addr_i is not 0; fwd_rsN_data_o SHALL then be rf_rd_wdata_o, and 0 otherwise.
REQ-021 stall_o SHALL be 1 when the state is FULL, the held rd is not 0, and the held rd equals rs1_addr_i or rs2_addr_i.
REQ-022 If both the ALU and the hold buffer target the same rd, the older entry (hold) SHALL be written first, preserving program order.

Reset
REQ-023 While rst_i=1 at a clock edge, the state SHALL become EMPTY and rf_wr_en_o, rf_rd_addr_o and rf_rd_wdata_o SHALL become 0.
REQ-024 A reset mid-operation SHALL discard the held entry and SHALL NOT produce a write for it.
REQ-025 During and after reset, lsu_ready_o SHALL read 1, and the fwd_* and stall_o outputs SHALL read 0.

Structure
REQ-026 The wb_state_e enum (EMPTY, FULL) and the register-count constant SHALL reside in beta_pkg.
REQ-027 The hold buffer SHALL be implemented as a sub-module named beta_wb_holdbuf.
REQ-028 The forwarding compare SHALL remain inline; no further hierarchy is required.

Verification
REQ-029 Scenario: ALU valid, rd=5, data=0xDEADBEEF -> next cycle rf_wr_en_o=1, addr=5, wdata=0xDEADBEEF.
REQ-030 Scenario: ALU rd=3 (0x11) and LSU rd=4 (0x22) valid in the same cycle -> cycle+1 writes r3=0x11 and lsu_ready_o=0; cycle+2 writes r4=0x22; cycle+3 lsu_ready_o=1.
REQ-031 Scenario: held LSU rd=7 with rs1_addr_i=7 -> stall_o=1 until the write cycle, when fwd_rs1_en_o=1 and fwd_rs1_data_o equals the load data.
REQ-032 Scenario: ALU rd=0, data=0xFFFF -> rf_wr_en_o stays 0 and fwd_*_en_o stays 0 even with rs1_addr_i=0.
REQ-033 Scenario: FULL state plus ALU valid for 3 consecutive cycles -> writes occur in arrival order, with lsu_ready_o=0 throughout.
REQ-034 Scenario: rst_i=1 while FULL -> no write of the held entry; the next cycle shows lsu_ready_o=1 and rf_wr_en_o=0.
